// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);
  localparam int unsigned ZERO_REG      = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xdata_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits: set by issue, cleared by writeback, set wins on a tie.
// Lookups report the state after this cycle's clear but before this cycle's set.
import rf_pkg::*;

module rf_scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_en_i,
  input  logic [AW-1:0]        clr_addr_i,
  input  logic                 set_en_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic [NUM_RD*AW-1:0] lk_addr_i,
  output logic [NUM_RD-1:0]    lk_busy_o,
  output logic                 any_busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != AW'(ZERO_REG))) busy_d[set_addr_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    lk_busy_o = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      logic [AW-1:0] a;
      a = lk_addr_i[p*AW +: AW];
      lk_busy_o[p] = busy_q[a] & ~(clr_en_i && (clr_addr_i == a));
    end
  end

  assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Integer register file with NUM_RD registered read ports and a busy scoreboard.
// Define RF_BYPASS_EN for write-first reads; otherwise same-cycle reads are read-first.
import rf_pkg::*;

module regfile_mp #(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic [NUM_RD-1:0]      rd_en_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   set_en_i,
  input  logic [AW-1:0]          set_addr_i,
  output logic                   any_busy_o
);

  logic [XLEN-1:0]              mem_q [NREGS];
  logic [NUM_RD-1:0][XLEN-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]            rd_busy_q, rd_busy_d;
  logic [NUM_RD-1:0]            lk_busy;
  logic                         wr_we;

  assign wr_we = wr_en_i && (wr_addr_i != AW'(ZERO_REG));

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_en_i   (wr_en_i),
    .clr_addr_i (wr_addr_i),
    .set_en_i   (set_en_i),
    .set_addr_i (set_addr_i),
    .lk_addr_i  (rd_addr_i),
    .lk_busy_o  (lk_busy),
    .any_busy_o (any_busy_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (wr_we) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      logic [AW-1:0] a;
      a = rd_addr_i[p*AW +: AW];
      if (rd_en_i[p]) begin
`ifdef RF_BYPASS_EN
        // wr_we already excludes register 0, so x0 still reads as zero.
        rd_data_d[p] = (wr_we && (wr_addr_i == a)) ? wr_data_i : mem_q[a];
`else
        rd_data_d[p] = mem_q[a];
`endif
        rd_busy_d[p] = lk_busy[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule
